// File: rtl/slave_rx_sequencer_if.sv
// Bus between the slave RX sequencer, the packet receiver, the handshake
// transmitter and the endpoint. The sequencer connects through the slave modport.
interface slave_rx_sequencer_if;
    logic       startRx;
    logic       endPointReady;
    logic       epStall;
    logic       isoEn;
    logic       expDataSeq;
    logic       RXPacketRdy;
    logic [3:0] RxPID;
    logic       CRCError;
    logic       bitStuffError;
    logic       RXOverflow;
    logic       RXTimeOut;
    logic       dataSequence;
    logic       sendPacketRdy;
    logic       getPacketEn;
    logic       sendPacketWEn;
    logic [3:0] sendPacketPID;
    logic       transDone;
    logic [7:0] transStatus;
    logic       toggleDataSeq;
    logic       rxBusy;

    modport slave (
        input  startRx, endPointReady, epStall, isoEn, expDataSeq,
        input  RXPacketRdy, RxPID, CRCError, bitStuffError, RXOverflow,
        input  RXTimeOut, dataSequence, sendPacketRdy,
        output getPacketEn, sendPacketWEn, sendPacketPID, transDone,
        output transStatus, toggleDataSeq, rxBusy
    );

    modport master (
        output startRx, endPointReady, epStall, isoEn, expDataSeq,
        output RXPacketRdy, RxPID, CRCError, bitStuffError, RXOverflow,
        output RXTimeOut, dataSequence, sendPacketRdy,
        input  getPacketEn, sendPacketWEn, sendPacketPID, transDone,
        input  transStatus, toggleDataSeq, rxBusy
    );
endinterface

// File: rtl/slave_rx_sequencer.sv
// Sequences reception of one DATA packet and the ACK/NAK/STALL handshake reply.
// Define SLV_RX_WDOG_EN to add an 8-bit watchdog that aborts a stalled WAIT_PKT.
module slave_rx_sequencer (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    slave_rx_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PKT,
        EVAL,
        SEND_HS,
        WAIT_HS,
        DONE
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] pidType_q, pidType_d;
    logic       crc_q, crc_d;
    logic       bs_q, bs_d;
    logic       ovf_q, ovf_d;
    logic       to_q, to_d;
    logic       dseq_q, dseq_d;
    logic       ack_q, ack_d;
    logic       nak_q, nak_d;
    logic       stall_q, stall_d;
    logic       match_q, match_d;
    logic       gpe_q, gpe_d;
    logic       wen_q, wen_d;
    logic [3:0] hsPid_q, hsPid_d;
    logic       done_q, done_d;
    logic [7:0] status_q, status_d;
    logic       tog_q, tog_d;
    logic       busy_q, busy_d;
    logic       dropPkt;
`ifdef SLV_RX_WDOG_EN
    logic [7:0] wdog_q, wdog_d;
`endif

    assign dropPkt = to_q | crc_q | bs_q | (pidType_q != 2'b11) | bus.isoEn;

    always_comb begin
        state_d   = state_q;
        pidType_d = pidType_q;
        crc_d     = crc_q;
        bs_d      = bs_q;
        ovf_d     = ovf_q;
        to_d      = to_q;
        dseq_d    = dseq_q;
        ack_d     = ack_q;
        nak_d     = nak_q;
        stall_d   = stall_q;
        match_d   = match_q;
        hsPid_d   = hsPid_q;
        status_d  = status_q;
        gpe_d     = 1'b0;
        wen_d     = 1'b0;
        done_d    = 1'b0;
        tog_d     = 1'b0;
`ifdef SLV_RX_WDOG_EN
        wdog_d    = wdog_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.startRx) begin
                    state_d = WAIT_PKT;
                    gpe_d   = 1'b1;
`ifdef SLV_RX_WDOG_EN
                    wdog_d  = 8'd0;
`endif
                end
            end
            WAIT_PKT: begin
                if (bus.RXPacketRdy) begin
                    pidType_d = bus.RxPID[1:0];
                    crc_d     = bus.CRCError;
                    bs_d      = bus.bitStuffError;
                    ovf_d     = bus.RXOverflow;
                    to_d      = bus.RXTimeOut;
                    dseq_d    = bus.dataSequence;
                    state_d   = EVAL;
                end
`ifdef SLV_RX_WDOG_EN
                else if (wdog_q == 8'd255) begin
                    // Watchdog expiry reports as a receiver timeout with nothing else seen.
                    crc_d   = 1'b0;
                    bs_d    = 1'b0;
                    ovf_d   = 1'b0;
                    to_d    = 1'b1;
                    dseq_d  = 1'b0;
                    ack_d   = 1'b0;
                    nak_d   = 1'b0;
                    stall_d = 1'b0;
                    match_d = 1'b0;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            EVAL: begin
                ack_d   = 1'b0;
                nak_d   = 1'b0;
                stall_d = 1'b0;
                match_d = (dseq_q == bus.expDataSeq);
                if (dropPkt) begin
                    hsPid_d = 4'h0;
                    state_d = DONE;
                end else begin
                    if (bus.epStall) begin
                        stall_d = 1'b1;
                        hsPid_d = 4'hE;
                    end else if (!bus.endPointReady || ovf_q) begin
                        nak_d   = 1'b1;
                        hsPid_d = 4'hA;
                    end else begin
                        ack_d   = 1'b1;
                        hsPid_d = 4'h2;
                    end
                    wen_d   = bus.sendPacketRdy;
                    state_d = SEND_HS;
                end
            end
            SEND_HS: begin
                // The write strobe is issued inside SEND_HS; leave once it has been seen.
                if (wen_q) begin
                    state_d = WAIT_HS;
                end else if (bus.sendPacketRdy) begin
                    wen_d = 1'b1;
                end
            end
            WAIT_HS: begin
                if (bus.sendPacketRdy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE) begin
            done_d   = 1'b1;
            status_d = {ack_d, dseq_d, stall_d, nak_d, to_d, ovf_d, bs_d, crc_d};
            tog_d    = ack_d & match_d;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pidType_q <= 2'b00;
            crc_q     <= 1'b0;
            bs_q      <= 1'b0;
            ovf_q     <= 1'b0;
            to_q      <= 1'b0;
            dseq_q    <= 1'b0;
            ack_q     <= 1'b0;
            nak_q     <= 1'b0;
            stall_q   <= 1'b0;
            match_q   <= 1'b0;
            gpe_q     <= 1'b0;
            wen_q     <= 1'b0;
            hsPid_q   <= 4'h0;
            done_q    <= 1'b0;
            status_q  <= 8'h00;
            tog_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SLV_RX_WDOG_EN
            wdog_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            pidType_q <= pidType_d;
            crc_q     <= crc_d;
            bs_q      <= bs_d;
            ovf_q     <= ovf_d;
            to_q      <= to_d;
            dseq_q    <= dseq_d;
            ack_q     <= ack_d;
            nak_q     <= nak_d;
            stall_q   <= stall_d;
            match_q   <= match_d;
            gpe_q     <= gpe_d;
            wen_q     <= wen_d;
            hsPid_q   <= hsPid_d;
            done_q    <= done_d;
            status_q  <= status_d;
            tog_q     <= tog_d;
            busy_q    <= busy_d;
`ifdef SLV_RX_WDOG_EN
            wdog_q    <= wdog_d;
`endif
        end
    end

    assign bus.getPacketEn   = gpe_q;
    assign bus.sendPacketWEn = wen_q;
    assign bus.sendPacketPID = hsPid_q;
    assign bus.transDone     = done_q;
    assign bus.transStatus   = status_q;
    assign bus.toggleDataSeq = tog_q;
    assign bus.rxBusy        = busy_q;

endmodule

// File: tb/tb_slave_rx_sequencer.sv
// Self-checking bench for slave_rx_sequencer: a cycle-indexed expectation model
// filled from the transaction rules, checked every cycle, plus literal results.
module tb_slave_rx_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   testsRun = 0;
    int   testsFailed = 0;

    slave_rx_sequencer_if bus ();

    slave_rx_sequencer dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bit         expGpe[int];
    bit         expWen[int];
    bit         expDone[int];
    bit         expTog[int];
    logic [7:0] statusAt[int];
    logic [3:0] pidAt[int];
    logic [7:0] curStatus = 8'h00;
    logic [3:0] curPid = 4'h0;
    int         busyStart = -1;
    int         busyEnd = -1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model of the transaction outcome, straight from the priority rules.
    task automatic decide(input logic [3:0] pid, input logic crc, bs, ovf, to, dseq,
                          input logic epRdy, stall, iso, expSeq,
                          output logic [3:0] hp, output logic [7:0] st, output bit tog);
        bit drop;
        drop = to || crc || bs || (pid[1:0] != 2'b11) || iso;
        if (drop)                 hp = 4'h0;
        else if (stall)           hp = 4'hE;
        else if (!epRdy || ovf)   hp = 4'hA;
        else                      hp = 4'h2;
        st  = {hp == 4'h2, dseq, hp == 4'hE, hp == 4'hA, to, ovf, bs, crc};
        tog = (hp == 4'h2) && (dseq == expSeq);
    endtask

    task automatic clearModel();
        expGpe.delete();
        expWen.delete();
        expDone.delete();
        expTog.delete();
        statusAt.delete();
        pidAt.delete();
        curStatus = 8'h00;
        curPid    = 4'h0;
        busyStart = -1;
        busyEnd   = -1;
    endtask

    always @(negedge clk) begin
        if (statusAt.exists(cyc)) curStatus = statusAt[cyc];
        if (pidAt.exists(cyc))    curPid    = pidAt[cyc];
        checkOutput("getPacketEn",   {31'd0, bus.getPacketEn},   {31'd0, expGpe.exists(cyc) != 0});
        checkOutput("sendPacketWEn", {31'd0, bus.sendPacketWEn}, {31'd0, expWen.exists(cyc) != 0});
        checkOutput("transDone",     {31'd0, bus.transDone},     {31'd0, expDone.exists(cyc) != 0});
        checkOutput("toggleDataSeq", {31'd0, bus.toggleDataSeq}, {31'd0, expTog.exists(cyc) != 0});
        checkOutput("rxBusy",        {31'd0, bus.rxBusy},
                    {31'd0, (busyStart >= 0) && (cyc >= busyStart) && (cyc <= busyEnd)});
        checkOutput("transStatus",   {24'd0, bus.transStatus},   {24'd0, curStatus});
        checkOutput("sendPacketPID", {28'd0, bus.sendPacketPID}, {28'd0, curPid});
    end

    // One transaction: fills the model's expectations, then drives it cycle by cycle.
    // preBusy/postBusy hold sendPacketRdy low before and after the handshake strobe.
    task automatic applyStimulus(input logic [3:0] pid, input logic crc, bs, ovf, to, dseq,
                                 input logic epRdy, stall, iso, expSeq,
                                 input int pktDelay, preBusy, postBusy,
                                 input bit noise, input bit abortHs);
        int n, m, w, d, abortCyc;
        logic [3:0] hp;
        logic [7:0] st;
        bit tog;
        @(posedge clk); #1;
        bus.endPointReady = epRdy;
        bus.epStall       = stall;
        bus.isoEn         = iso;
        bus.expDataSeq    = expSeq;
        bus.RxPID         = pid;
        bus.CRCError      = crc;
        bus.bitStuffError = bs;
        bus.RXOverflow    = ovf;
        bus.RXTimeOut     = to;
        bus.dataSequence  = dseq;
        bus.startRx       = 1'b1;
        bus.RXPacketRdy   = noise;
        n = cyc;
        m = n + 1 + pktDelay;
        decide(pid, crc, bs, ovf, to, dseq, epRdy, stall, iso, expSeq, hp, st, tog);
        w = m + 2 + preBusy;
        if (hp != 4'h0) d = w + 2 + postBusy;
        else            d = m + 2;
        abortCyc = abortHs ? w + 3 : -1;
        expGpe[n + 1] = 1'b1;
        if (hp != 4'h0) expWen[w] = 1'b1;
        expDone[d]   = 1'b1;
        statusAt[d]  = st;
        pidAt[m + 2] = hp;
        if (tog) expTog[d] = 1'b1;
        busyStart = n + 1;
        busyEnd   = d;
        while (cyc < d) begin
            @(posedge clk); #1;
            if (cyc == abortCyc) begin
                rst_n = 1'b0;
                clearModel();
                #1;
                checkOutput("reset rxBusy",        {31'd0, bus.rxBusy},        32'd0);
                checkOutput("reset transStatus",   {24'd0, bus.transStatus},   32'd0);
                checkOutput("reset sendPacketPID", {28'd0, bus.sendPacketPID}, 32'd0);
                checkOutput("reset sendPacketWEn", {31'd0, bus.sendPacketWEn}, 32'd0);
                bus.startRx     = 1'b0;
                bus.RXPacketRdy = 1'b0;
                bus.sendPacketRdy = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            bus.startRx     = noise && (cyc == m + 1);
            bus.RXPacketRdy = (cyc == m);
            if (hp != 4'h0 && ((cyc >= m + 1 && cyc <= m + preBusy) ||
                               (cyc >= w + 1 && cyc <= w + postBusy)))
                bus.sendPacketRdy = 1'b0;
            else
                bus.sendPacketRdy = 1'b1;
        end
        @(posedge clk); #1;
        bus.startRx       = 1'b0;
        bus.RXPacketRdy   = 1'b0;
        bus.sendPacketRdy = 1'b1;
    endtask

    task automatic checkResult(input string name, input logic [7:0] st, input logic [3:0] pid);
        checkOutput({name, " status"}, {24'd0, bus.transStatus},   {24'd0, st});
        checkOutput({name, " pid"},    {28'd0, bus.sendPacketPID}, {28'd0, pid});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.startRx = 1'b0;       bus.endPointReady = 1'b0; bus.epStall = 1'b0;
        bus.isoEn = 1'b0;         bus.expDataSeq = 1'b0;    bus.RXPacketRdy = 1'b0;
        bus.RxPID = 4'h0;         bus.CRCError = 1'b0;      bus.bitStuffError = 1'b0;
        bus.RXOverflow = 1'b0;    bus.RXTimeOut = 1'b0;     bus.dataSequence = 1'b0;
        bus.sendPacketRdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset idle busy",   {31'd0, bus.rxBusy},      32'd0);
        checkOutput("reset idle status", {24'd0, bus.transStatus}, 32'd0);
        rst_n = 1'b1;

        //            pid   crc   bs    ovf   to    dseq  epRdy stall iso   exp   dly pre post noise abort
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0);
        checkResult("ack", 8'h80, 4'h2);
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 0, 1'b0, 1'b0);
        checkResult("nak", 8'h10, 4'hA);
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkResult("stall", 8'h20, 4'hE);
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 3, 1'b0, 1'b0);
        checkResult("stall over nak", 8'h24, 4'hE);
        applyStimulus(4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkResult("crc", 8'h41, 4'h0);
        applyStimulus(4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkResult("duplicate", 8'hC0, 4'h2);
        applyStimulus(4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkResult("iso", 8'h40, 4'h0);
        applyStimulus(4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkResult("non-data pid", 8'h04, 4'h0);
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkResult("overflow nak", 8'h14, 4'hA);
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkResult("timeout first", 8'h08, 4'h0);
        applyStimulus(4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 2, 1'b1, 1'b0);
        checkResult("ack toggle1 noise", 8'hC0, 4'h2);
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 10, 1'b0, 1'b1);
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkResult("after reset", 8'h10, 4'hA);

`ifdef SLV_RX_WDOG_EN
        begin
            int n;
            @(posedge clk); #1;
            bus.startRx = 1'b1;
            n = cyc;
            expGpe[n + 1]     = 1'b1;
            expDone[n + 257]  = 1'b1;
            statusAt[n + 257] = 8'h08;
            busyStart = n + 1;
            busyEnd   = n + 257;
            @(posedge clk); #1;
            bus.startRx = 1'b0;
            repeat (257) @(posedge clk);
            #1;
            checkOutput("watchdog status", {24'd0, bus.transStatus}, 32'h08);
        end
`else
        applyStimulus(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 300, 0, 0, 1'b0, 1'b0);
        checkResult("long wait", 8'h80, 4'h2);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
